// File: rtl/lite16_pkg.sv
// lite16 shared definitions: FSM states, instruction classes, IR field positions.
// Used by alu_sequencer and lite16_decode.
package lite16_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_EXEC   = 3'd3;
    localparam state_t ST_HALT   = 3'd4;

    localparam logic [1:0] CLS_R    = 2'b00;
    localparam logic [1:0] CLS_RI   = 2'b01;
    localparam logic [1:0] CLS_JMP  = 2'b10;
    localparam logic [1:0] CLS_HALT = 2'b11;

    localparam int CLS_HI = 15;
    localparam int CLS_LO = 14;
    localparam int OP_HI  = 13;
    localparam int OP_LO  = 11;
    localparam int RD_HI  = 10;
    localparam int RD_LO  = 8;
    localparam int RS1_HI = 7;
    localparam int RS1_LO = 5;
    localparam int RS2_HI = 4;
    localparam int RS2_LO = 2;

endpackage

// File: rtl/lite16_decode.sv
// lite16 instruction decoder: splits the IR into fields and class flags.
// Purely combinational; bits [1:0] are reserved.
module lite16_decode
    import lite16_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  codeop,
    output logic [2:0]  rd,
    output logic [2:0]  rs1,
    output logic [2:0]  rs2,
    output logic        is_r,
    output logic        is_ri,
    output logic        is_jmp,
    output logic        is_halt
);

    logic [1:0] cls;
    logic       unused_rsvd;

    assign unused_rsvd = ^ir[1:0];

    // Field extraction and class flags
    always_comb begin
        cls     = ir[CLS_HI:CLS_LO];
        codeop  = ir[OP_HI:OP_LO];
        rd      = ir[RD_HI:RD_LO];
        rs1     = ir[RS1_HI:RS1_LO];
        rs2     = ir[RS2_HI:RS2_LO];
        is_r    = (cls == CLS_R);
        is_ri   = (cls == CLS_RI);
        is_jmp  = (cls == CLS_JMP);
        is_halt = (cls == CLS_HALT);
    end

endmodule

// File: rtl/alu_sequencer.sv
// lite16 sequencer: fetch/decode/exec FSM owning pc and IR.
// Optional retired-instruction counter under ALU_SEQ_RETIRE_CNT_EN.
module alu_sequencer
    import lite16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [2:0]  rf_ra,
    output logic [2:0]  rf_rb,
    output logic [2:0]  rf_wa,
    output logic        rf_we,
    output logic [2:0]  alu_codeop,
    output logic        alu_ri,
    output logic        alu_jmp,
    input  logic        alu_cmp,
    input  logic [15:0] br_target,
    output logic        busy,
    output logic        halted
`ifdef ALU_SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0] retired
`endif
);

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;

    logic [2:0] codeop, rd, rs1, rs2;
    logic       is_r, is_ri, is_jmp, is_halt;
    logic       in_fetch, in_dx, in_exec, idle_like, take_jmp;

    lite16_decode u_dec (
        .ir      (ir_q),
        .codeop  (codeop),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .is_r    (is_r),
        .is_ri   (is_ri),
        .is_jmp  (is_jmp),
        .is_halt (is_halt)
    );

    assign in_fetch  = (state_q == ST_FETCH);
    assign in_exec   = (state_q == ST_EXEC);
    assign in_dx     = (state_q == ST_DECODE) || in_exec;
    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_HALT);
    assign take_jmp  = is_jmp && alu_cmp;

    // Next-state, pc and IR update
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_halt) begin
                    state_d = ST_HALT;
                    pc_d    = pc_q + 16'd1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = take_jmp ? br_target : pc_q + 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from state and registered IR
    always_comb begin
        imem_req   = in_fetch;
        imem_addr  = in_fetch ? pc_q : 16'h0000;
        rf_ra      = in_dx ? rs1 : 3'd0;
        rf_rb      = in_dx ? rs2 : 3'd0;
        rf_wa      = in_dx ? rd : 3'd0;
        alu_codeop = in_dx ? codeop : 3'd0;
        alu_ri     = in_dx && is_ri;
        alu_jmp    = in_dx && is_jmp;
        rf_we      = in_exec &&
                     (is_r || is_ri || (take_jmp && (rd != 3'd0)));
        busy       = !idle_like;
        halted     = (state_q == ST_HALT);
    end

    // FSM, pc and IR registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

`ifdef ALU_SEQ_RETIRE_CNT_EN
    logic [15:0] retired_q, retired_d;

    // Retired count: cleared on accepted start, bumped per EXEC cycle
    always_comb begin
        retired_d = retired_q;
        if (idle_like && start) begin
            retired_d = '0;
        end else if (in_exec) begin
            retired_d = retired_q + 16'd1;
        end
    end

    // Retired counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: driver pushes expected fetches and
// register writes, a negedge monitor pops and compares them.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, imem_ack, alu_cmp;
    logic [15:0] imem_data, br_target;
    logic        imem_req, rf_we, alu_ri, alu_jmp, busy, halted;
    logic [15:0] imem_addr;
    logic [2:0]  rf_ra, rf_rb, rf_wa, alu_codeop;
`ifdef ALU_SEQ_RETIRE_CNT_EN
    logic [15:0] retired;
`endif

    typedef struct packed {
        logic [2:0] wa;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [2:0] op;
        logic       ri;
        logic       jmp;
    } wexp_t;

    logic [15:0] fq[$];
    wexp_t       wq[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          ack_cyc = 0;

    alu_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .rf_ra      (rf_ra),
        .rf_rb      (rf_rb),
        .rf_wa      (rf_wa),
        .rf_we      (rf_we),
        .alu_codeop (alu_codeop),
        .alu_ri     (alu_ri),
        .alu_jmp    (alu_jmp),
        .alu_cmp    (alu_cmp),
        .br_target  (br_target),
        .busy       (busy),
        .halted     (halted)
`ifdef ALU_SEQ_RETIRE_CNT_EN
        ,
        .retired    (retired)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_w(input logic [2:0] wa, input logic [2:0] ra,
                          input logic [2:0] rb, input logic [2:0] op,
                          input logic ri, input logic jmp);
        wexp_t e;
        e.wa = wa; e.ra = ra; e.rb = rb; e.op = op; e.ri = ri; e.jmp = jmp;
        wq.push_back(e);
    endtask

    // Monitor: every accepted fetch and every register write is checked
    always @(negedge clk) begin : mon
        wexp_t e;
        logic [15:0] a;
        if (rst_n) begin
            if (imem_req && imem_ack) begin
                ack_cyc = cyc;
                if (fq.size() == 0) chk("fetch_unexpected", imem_ack, 0);
                else begin
                    a = fq.pop_front();
                    chk("fetch_addr", imem_addr, a);
                end
            end
            if (rf_we) begin
                if (wq.size() == 0) chk("we_unexpected", rf_we, 0);
                else begin
                    e = wq.pop_front();
                    chk("we_wa", rf_wa, e.wa);
                    chk("we_ra", rf_ra, e.ra);
                    chk("we_rb", rf_rb, e.rb);
                    chk("we_codeop", alu_codeop, e.op);
                    chk("we_ri", alu_ri, e.ri);
                    chk("we_jmp", alu_jmp, e.jmp);
                    chk("we_latency", cyc - ack_cyc, 2);
                end
            end
        end
    end

    // Serve one fetch at addr after delay withheld cycles
    task automatic serve(input logic [15:0] addr, input logic [15:0] data,
                         input int delay, input logic cmp,
                         input logic [15:0] tgt, input bit bstart);
        int n = 0;
        while (!imem_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!imem_req) begin
            chk("fetch_timeout", imem_req, 1);
            return;
        end
        for (int i = 0; i < delay; i++) begin
            chk("hold_req", imem_req, 1);
            chk("hold_addr", imem_addr, addr);
            @(posedge clk); #1;
        end
        fq.push_back(addr);
        imem_ack  = 1'b1;
        imem_data = data;
        alu_cmp   = cmp;
        br_target = tgt;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        if (bstart) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic wait_halt();
        int n = 0;
        while (!halted && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("halted", halted, 1);
        chk("halt_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("halt_no_req", imem_req, 0);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0;
        imem_data = '0; alu_cmp = 1'b0; br_target = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_we", rf_we, 0);
        chk("rst_jmp", alu_jmp, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_fetch_before_start", imem_req, 0);
        pulse_start();
        chk("busy_after_start", busy, 1);

        // R: codeop 001, rd 2, rs1 1, rs2 3
        push_w(3'd2, 3'd1, 3'd3, 3'd1, 1'b0, 1'b0);
        serve(16'h0000, 16'h0A2C, 0, 1'b0, 16'h0000, 1'b0);
        // JMP rd 3 taken to 0x0040 with link write
        push_w(3'd3, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);
        serve(16'h0001, 16'h8300, 0, 1'b1, 16'h0040, 1'b0);
        // JMP not taken, no write; start while busy ignored
        serve(16'h0040, 16'h8300, 0, 1'b0, 16'h1234, 1'b1);
        // JMP rd 0 taken to 0xFFFF, no write
        serve(16'h0041, 16'h8000, 0, 1'b1, 16'hFFFF, 1'b0);
        // RI codeop 001, rd 5, rs1 4 at 0xFFFF; pc wraps to 0
        push_w(3'd5, 3'd4, 3'd0, 3'd1, 1'b1, 1'b0);
        serve(16'hFFFF, 16'h4D80, 0, 1'b0, 16'h0000, 1'b0);
        // HALT with ack withheld 5 cycles
        serve(16'h0000, 16'hC000, 5, 1'b0, 16'h0000, 1'b0);
        wait_halt();
`ifdef ALU_SEQ_RETIRE_CNT_EN
        chk("retired_5", retired, 5);
`endif

        // Restart from pc 0: three instructions then HALT
        pulse_start();
        push_w(3'd2, 3'd1, 3'd3, 3'd2, 1'b0, 1'b0);
        serve(16'h0000, 16'h122C, 0, 1'b0, 16'h0000, 1'b0);
        push_w(3'd7, 3'd7, 3'd7, 3'd7, 1'b0, 1'b0);
        serve(16'h0001, 16'h3FFC, 0, 1'b0, 16'h0000, 1'b0);
        push_w(3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
        serve(16'h0002, 16'h4000, 0, 1'b0, 16'h0000, 1'b0);
        serve(16'h0003, 16'hC000, 0, 1'b0, 16'h0000, 1'b0);
        wait_halt();
`ifdef ALU_SEQ_RETIRE_CNT_EN
        chk("retired_3", retired, 3);
`endif

        // Asynchronous reset in the middle of a fetch
        pulse_start();
        chk("midrst_req_before", imem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", imem_req, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_addr", imem_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_idle", imem_req, 0);
        chk("fq_drained", fq.size(), 0);
        chk("wq_drained", wq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
